// File: rtl/seg7_monitor.sv
// -----------------------------------------------------------------------------
// seg7_monitor
//
// Watches the seven segment lines of a display that is driven by some other
// clock domain. It recovers the steady patterns and decodes them as hex
// glyphs. It also keeps simple frame statistics:
//   - how many pattern changes were accepted,
//   - the spacing between the last two changes,
//   - whether the display has stopped changing.
//
// Ports
//   clk_i           single clock, all state updates on the rising edge
//   reset_i         synchronous active-high reset (highest priority)
//   seg_in_i[6:0]   observed segment lines, bit0=a .. bit6=g, asynchronous
//   clear_i         synchronous statistics clear, active-high
//   frame_valid_o   one-cycle pulse on every accepted pattern change
//   frame_pat_o     last accepted pattern
//   digit_out_o     hex value of frame_pat_o (0 when not a glyph)
//   digit_ok_o      frame_pat_o is one of the 16 hex glyphs
//   frame_cnt_o     number of accepted changes (wraps)
//   period_out_o    cycles between the last two frame_valid_o pulses
//   period_valid_o  period_out_o holds a measured value
//   stalled_o       no accepted change for TIMEOUT cycles
//
// Parameters
//   STABLE_CYCLES   consecutive identical synchronized samples needed to
//                   accept a pattern (2..255)
//   TIMEOUT         gap length, in cycles, at which stalled_o asserts
// -----------------------------------------------------------------------------
module seg7_monitor #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic [24:0] TIMEOUT       = 25'd20_000_000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [6:0]  seg_in_i,
    input  logic        clear_i,
    output logic        frame_valid_o,
    output logic [6:0]  frame_pat_o,
    output logic [3:0]  digit_out_o,
    output logic        digit_ok_o,
    output logic [15:0] frame_cnt_o,
    output logic [24:0] period_out_o,
    output logic        period_valid_o,
    output logic        stalled_o
);

    // The sample that loads the candidate counts as the first identical
    // sample. Each later increment of the stable counter adds one more.
    // The sample presented on the accepting edge adds one more again.
    // So acceptance happens when the counter already holds STABLE_CYCLES-2.
    localparam logic [7:0]  ACCEPT_CNT = 8'(STABLE_CYCLES - 2);
    localparam logic [7:0]  STAB_MAX   = 8'hFF;
    localparam logic [24:0] GAP_MAX    = 25'h1FF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    // Hex glyph decode: returns {ok, digit}; non-glyph patterns give 0.
    function automatic logic [4:0] glyph_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    // Synchronizer, filter and statistics registers.
    logic [6:0]  seg_meta_q;
    logic [6:0]  seg_sync_q;
    logic [6:0]  cand_q;
    logic [6:0]  cand_d;
    logic [7:0]  stab_q;
    logic [7:0]  stab_d;
    logic        frame_valid_q;
    logic [6:0]  frame_pat_q;
    logic [15:0] frame_cnt_q;
    logic [24:0] period_q;
    logic        period_valid_q;
    logic        stalled_q;
    logic [24:0] gap_q;
    state_t      state_q;

    logic        accept_s;
    logic [24:0] gap_inc_s;
    logic        timeout_hit_s;
    logic [4:0]  glyph_s;

    // Two-flop synchronizer for the asynchronous segment lines.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            seg_meta_q <= 7'h00;
            seg_sync_q <= 7'h00;
        end else begin
            seg_meta_q <= seg_in_i;
            seg_sync_q <= seg_meta_q;
        end
    end

    // Filter next state: a new value restarts the stable count.
    // An unchanged value extends the count, which saturates at its maximum.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        if (seg_sync_q != cand_q) begin
            cand_d = seg_sync_q;
            stab_d = 8'd0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + 8'd1;
        end else begin
            stab_d = stab_q;
        end
    end

    // Filter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cand_q <= 7'h00;
            stab_q <= 8'd0;
        end else begin
            cand_q <= cand_d;
            stab_q <= stab_d;
        end
    end

    // A candidate is accepted once it has filled the stable window and
    // differs from the current frame pattern. The comparison against
    // frame_pat_q keeps a saturated counter from firing a second time.
    assign accept_s = (seg_sync_q == cand_q) &&
                      (stab_q >= ACCEPT_CNT) &&
                      (cand_q != frame_pat_q);

    // Gap value for the coming cycle. It is also the spacing between the
    // previous pulse and a pulse issued on this edge.
    assign gap_inc_s     = (gap_q == GAP_MAX) ? gap_q : (gap_q + 25'd1);
    assign timeout_hit_s = (gap_inc_s >= TIMEOUT);

    // Frame pattern, gap counter, frame counter and period/stall FSM.
    // clear_i resets the statistics but still lets a coincident accept
    // update frame_pat; only the pulse and counters are suppressed.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            frame_valid_q  <= 1'b0;
            frame_pat_q    <= 7'h00;
            frame_cnt_q    <= 16'd0;
            period_q       <= 25'd0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b0;
            gap_q          <= 25'd0;
            state_q        <= ST_IDLE;
        end else begin
            frame_valid_q <= 1'b0;
            if (accept_s) begin
                frame_pat_q <= cand_q;
            end
            if (clear_i) begin
                frame_cnt_q    <= 16'd0;
                period_q       <= 25'd0;
                period_valid_q <= 1'b0;
                stalled_q      <= 1'b0;
                gap_q          <= 25'd0;
                state_q        <= ST_IDLE;
            end else begin
                if (accept_s) begin
                    frame_valid_q <= 1'b1;
                    frame_cnt_q   <= frame_cnt_q + 16'd1;
                    gap_q         <= 25'd0;
                end else begin
                    gap_q         <= gap_inc_s;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (accept_s) begin
                            state_q <= ST_FIRST;
                        end
                    end
                    ST_FIRST: begin
                        if (accept_s) begin
                            state_q        <= ST_RUN;
                            period_q       <= gap_inc_s;
                            period_valid_q <= 1'b1;
                        end else if (timeout_hit_s) begin
                            state_q   <= ST_STALL;
                            stalled_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (accept_s) begin
                            period_q <= gap_inc_s;
                        end else if (timeout_hit_s) begin
                            state_q   <= ST_STALL;
                            stalled_q <= 1'b1;
                        end
                    end
                    ST_STALL: begin
                        if (accept_s) begin
                            state_q        <= ST_RUN;
                            stalled_q      <= 1'b0;
                            period_q       <= gap_inc_s;
                            period_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign glyph_s        = glyph_decode(frame_pat_q);
    assign digit_ok_o     = glyph_s[4];
    assign digit_out_o    = glyph_s[3:0];
    assign frame_valid_o  = frame_valid_q;
    assign frame_pat_o    = frame_pat_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign period_out_o   = period_q;
    assign period_valid_o = period_valid_q;
    assign stalled_o      = stalled_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// -----------------------------------------------------------------------------
// tb_seg7_monitor
//
// Directed stimulus with a scoreboard. For every pattern change the stimulus
// expects the monitor to accept, it pushes the expected pulse record. The
// record holds the cycle number and the output values. A separate monitor
// process pops and compares a record on every frame_valid pulse.
// -----------------------------------------------------------------------------
module tb_seg7_monitor;

    logic        clk;
    logic        reset;
    logic [6:0]  seg_in;
    logic        clear;
    logic        frame_valid;
    logic [6:0]  frame_pat;
    logic [3:0]  digit_out;
    logic        digit_ok;
    logic [15:0] frame_cnt;
    logic [24:0] period_out;
    logic        period_valid;
    logic        stalled;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [6:0]  pat;
        logic [3:0]  digit;
        logic        ok;
        logic [15:0] cnt;
        logic [24:0] period;
        logic        pv;
        logic        stalled;
    } exp_t;

    exp_t exp_q[$];

    seg7_monitor #(
        .STABLE_CYCLES(16),
        .TIMEOUT      (25'd1000)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .seg_in_i      (seg_in),
        .clear_i       (clear),
        .frame_valid_o (frame_valid),
        .frame_pat_o   (frame_pat),
        .digit_out_o   (digit_out),
        .digit_ok_o    (digit_ok),
        .frame_cnt_o   (frame_cnt),
        .period_out_o  (period_out),
        .period_valid_o(period_valid),
        .stalled_o     (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int at, input logic [6:0] pat, input logic [3:0] dig,
                                input logic ok, input logic [15:0] cnt,
                                input logic [24:0] per, input logic pv);
        exp_t e;
        e.cyc = at; e.pat = pat; e.digit = dig; e.ok = ok; e.cnt = cnt;
        e.period = per; e.pv = pv; e.stalled = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},  32'(frame_valid),  32'd0);
        chk({tag, "_pat"},    32'(frame_pat),    32'd0);
        chk({tag, "_digit"},  32'(digit_out),    32'd0);
        chk({tag, "_ok"},     32'(digit_ok),     32'd0);
        chk({tag, "_cnt"},    32'(frame_cnt),    32'd0);
        chk({tag, "_period"}, 32'(period_out),   32'd0);
        chk({tag, "_pv"},     32'(period_valid), 32'd0);
        chk({tag, "_stall"},  32'(stalled),      32'd0);
    endtask

    // Scoreboard monitor: every pulse must match the oldest expected record.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_pulse actual=pat %0h at cycle %0d required=no pulse",
                         frame_pat, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle",  32'(cyc),          32'(e.cyc));
                chk("pulse_pat",    32'(frame_pat),    32'(e.pat));
                chk("pulse_digit",  32'(digit_out),    32'(e.digit));
                chk("pulse_ok",     32'(digit_ok),     32'(e.ok));
                chk("pulse_cnt",    32'(frame_cnt),    32'(e.cnt));
                chk("pulse_period", 32'(period_out),   32'(e.period));
                chk("pulse_pv",     32'(period_valid), 32'(e.pv));
                chk("pulse_stall",  32'(stalled),      32'(e.stalled));
            end
        end
    end

    initial begin
        int c0;
        int p;
        reset  = 1'b1;
        clear  = 1'b0;
        seg_in = 7'h00;
        step(3);
        check_reset_outputs("rst");

        // Release reset with 06 on the lines: pulse 18 cycles later, no period yet.
        reset  = 1'b0;
        seg_in = 7'h06;
        c0 = cyc;
        expect_pulse(c0 + 18, 7'h06, 4'h1, 1'b1, 16'd1, 25'd0, 1'b0);
        step(25);

        // 5B: first measured period (pulses 25 cycles apart).
        seg_in = 7'h5B;
        c0 = cyc;
        expect_pulse(c0 + 18, 7'h5B, 4'h2, 1'b1, 16'd2, 25'd25, 1'b1);
        step(100);

        // 4F exactly 100 cycles after 5B.
        seg_in = 7'h4F;
        c0 = cyc;
        expect_pulse(c0 + 18, 7'h4F, 4'h3, 1'b1, 16'd3, 25'd100, 1'b1);
        step(30);

        // Back to 06, then a 10-cycle 7F glitch that must be filtered out.
        seg_in = 7'h06;
        c0 = cyc;
        p  = c0 + 18;
        expect_pulse(p, 7'h06, 4'h1, 1'b1, 16'd4, 25'd30, 1'b1);
        step(30);
        seg_in = 7'h7F;
        step(10);
        seg_in = 7'h06;
        step(40);
        chk("glitch_pat", 32'(frame_pat), 32'h06);
        chk("glitch_cnt", 32'(frame_cnt), 32'd4);

        // Hold 06: stalled rises exactly when the gap reaches 1000.
        step((p + 999) - cyc);
        chk("stall_before", 32'(stalled), 32'd0);
        step(1);
        chk("stall_at", 32'(stalled), 32'd1);
        seg_in = 7'h5B;
        expect_pulse(cyc + 18, 7'h5B, 4'h2, 1'b1, 16'd5, 25'd1018, 1'b1);
        step(30);
        chk("stall_cleared", 32'(stalled), 32'd0);

        // Non-glyph pattern 49.
        seg_in = 7'h49;
        expect_pulse(cyc + 18, 7'h49, 4'h0, 1'b0, 16'd6, 25'd30, 1'b1);
        step(30);

        // clear coinciding with the accept of 3F: no pulse, pattern still loads.
        seg_in = 7'h3F;
        step(17);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clr_valid",  32'(frame_valid),  32'd0);
        chk("clr_pat",    32'(frame_pat),    32'h3F);
        chk("clr_digit",  32'(digit_out),    32'h0);
        chk("clr_ok",     32'(digit_ok),     32'd1);
        chk("clr_cnt",    32'(frame_cnt),    32'd0);
        chk("clr_period", 32'(period_out),   32'd0);
        chk("clr_pv",     32'(period_valid), 32'd0);
        chk("clr_stall",  32'(stalled),      32'd0);

        // After clear the FSM is back in IDLE: next accept gives no period.
        seg_in = 7'h06;
        expect_pulse(cyc + 18, 7'h06, 4'h1, 1'b1, 16'd1, 25'd0, 1'b0);
        step(30);

        // Reset in the middle of a filter window discards the candidate.
        seg_in = 7'h7F;
        step(10);
        reset  = 1'b1;
        seg_in = 7'h00;
        step(1);
        check_reset_outputs("midrst");
        step(2);
        reset = 1'b0;
        step(40);
        check_reset_outputs("blank");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
